alu_flag_unit: RTL and testbench

//  Multi-cycle subtract-and-flag stage sitting directly upstream of the ALU comparer.

---
 rtl/alu_flag_unit.sv | 198 +++++++++++++++++++
 tb/tb_alu_flag_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_unit.sv
// ---------------------------------------------------------------------------
// alu_flag_unit
//   Multi-cycle subtract-and-flag stage feeding the ALU comparer.
//   Computes diff = a - b as a + ~b + 1, one CHUNK-bit slice per clock,
//   LSB slice first, and derives the zero and negative (a < b) flags.
//
// Parameters
//   WIDTH  operand / diff width (default 32)
//   CHUNK  slice width processed per cycle (default 8), WIDTH % CHUNK == 0
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   start        in   request, accepted only in IDLE or DONE
//   a, b         in   operands, sampled on the acceptance edge
//   is_unsigned  in   (only with ALU_FLAG_UNSIGNED_EN) unsigned compare select
//   busy         out  high while the subtraction is running
//   valid        out  high while the result is presented
//   zero         out  diff == 0
//   negative     out  a < b (signed, or unsigned when selected)
//   diff         out  a - b modulo 2^WIDTH
//
// Optional feature macro: ALU_FLAG_UNSIGNED_EN
//   Adds the is_unsigned port; when latched high, negative is the unsigned
//   borrow of the full subtraction instead of the signed N xor V rule.
// ---------------------------------------------------------------------------
module alu_flag_unit #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef ALU_FLAG_UNSIGNED_EN
   input  logic             is_unsigned,
`endif
   output logic             busy,
   output logic             valid,
   output logic             zero,
   output logic             negative,
   output logic [WIDTH-1:0] diff
);

   localparam int NSLICE = WIDTH / CHUNK;
   // Keep the counter at least one bit wide so the single-slice case still elaborates.
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

   logic [1:0]       state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [WIDTH-1:0] a_q,       a_d;
   logic [WIDTH-1:0] b_q,       b_d;
   logic [WIDTH-1:0] dacc_q,    dacc_d;
   logic             carry_q,   carry_d;
   logic             zacc_q,    zacc_d;
   logic [WIDTH-1:0] diff_q,    diff_d;
   logic             zero_q,    zero_d;
   logic             neg_q,     neg_d;
   logic             busy_q,    busy_d;
   logic             valid_q,   valid_d;
`ifdef ALU_FLAG_UNSIGNED_EN
   logic             uns_q,     uns_d;
`endif

   // Current slice arithmetic and the diff as it looks once this slice is merged.
   logic [CHUNK-1:0] a_sl_s;
   logic [CHUNK-1:0] b_sl_s;
   logic [CHUNK:0]   sum_s;
   logic [WIDTH-1:0] dfull_s;
   logic             msb_s;
   logic             ovf_s;
   logic             neg_signed_s;

   // Slice adder: a + ~b + carry, with the result merged into the partial diff.
   always_comb begin
      a_sl_s  = a_q[cnt_q*CHUNK +: CHUNK];
      b_sl_s  = b_q[cnt_q*CHUNK +: CHUNK];
      sum_s   = {1'b0, a_sl_s} + {1'b0, ~b_sl_s} + {{CHUNK{1'b0}}, carry_q};
      dfull_s = dacc_q;
      dfull_s[cnt_q*CHUNK +: CHUNK] = sum_s[CHUNK-1:0];
      msb_s   = dfull_s[WIDTH-1];
      // Signed overflow: operands differ in sign and the result sign differs from a.
      ovf_s   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ msb_s);
      neg_signed_s = msb_s ^ ovf_s;
   end

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      dacc_d  = dacc_q;
      carry_d = carry_q;
      zacc_d  = zacc_q;
      diff_d  = diff_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
`ifdef ALU_FLAG_UNSIGNED_EN
      uns_d   = uns_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
`ifdef ALU_FLAG_UNSIGNED_EN
               uns_d   = is_unsigned;
`endif
               carry_d = 1'b1;
               zacc_d  = 1'b1;
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_RUN;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            dacc_d  = dfull_s;
            carry_d = sum_s[CHUNK];
            zacc_d  = zacc_q & (sum_s[CHUNK-1:0] == {CHUNK{1'b0}});
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               diff_d  = dfull_s;
               zero_d  = zacc_q & (sum_s[CHUNK-1:0] == {CHUNK{1'b0}});
`ifdef ALU_FLAG_UNSIGNED_EN
               // No carry out of a + ~b + 1 means a borrow occurred: a < b unsigned.
               if (uns_q) begin
                  neg_d = ~sum_s[CHUNK];
               end else begin
                  neg_d = neg_signed_s;
               end
`else
               neg_d   = neg_signed_s;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d  = (state_d == ST_RUN);
      valid_d = (state_d == ST_DONE);
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         dacc_q  <= {WIDTH{1'b0}};
         carry_q <= 1'b0;
         zacc_q  <= 1'b0;
         diff_q  <= {WIDTH{1'b0}};
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
`ifdef ALU_FLAG_UNSIGNED_EN
         uns_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dacc_q  <= dacc_d;
         carry_q <= carry_d;
         zacc_q  <= zacc_d;
         diff_q  <= diff_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
`ifdef ALU_FLAG_UNSIGNED_EN
         uns_q   <= uns_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign valid    = valid_q;
   assign zero     = zero_q;
   assign negative = neg_q;
   assign diff     = diff_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_flag_unit
//   Directed-vector bench with a scoreboard: the driver pushes hand-computed
//   results, a monitor pops and compares on every rising edge of valid.
// ---------------------------------------------------------------------------
module tb_alu_flag_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        is_uns = 1'b0;
   logic        busy;
   logic        valid;
   logic        zero;
   logic        negative;
   logic [31:0] diff;

   typedef struct {
      logic [31:0] diff;
      logic        zero;
      logic        neg;
      int          acc_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   logic prev_valid = 1'b0;

   alu_flag_unit #(.WIDTH(32), .CHUNK(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
`ifdef ALU_FLAG_UNSIGNED_EN
      .is_unsigned (is_uns),
`endif
      .busy        (busy),
      .valid       (valid),
      .zero        (zero),
      .negative    (negative),
      .diff        (diff)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: compare each presented result against the scoreboard head.
   always @(negedge clk) begin
      prev_valid <= valid;
      if (valid && !prev_valid && !rst) begin
         if (sb_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("diff", diff, e.diff);
            check("zero", {31'd0, zero}, {31'd0, e.zero});
            check("negative", {31'd0, negative}, {31'd0, e.neg});
            check("latency", cyc - e.acc_cyc, 32'd4);
            check("busy_in_done", {31'd0, busy}, 32'd0);
         end
      end
   end

   // Present one request for one cycle; operands are scrambled afterwards.
   task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic uns,
                        input logic [31:0] ed, input logic ez, input logic en, input bit push);
      exp_t e;
      @(negedge clk);
      start  = 1'b1;
      a      = ta;
      b      = tb;
      is_uns = uns;
      if (push) begin
         e.diff = ed; e.zero = ez; e.neg = en; e.acc_cyc = cyc + 1;
         sb_q.push_back(e);
      end
      @(negedge clk);
      start  = 1'b0;
      a      = 32'hDEAD_BEEF;
      b      = 32'h1234_5678;
      is_uns = ~uns;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!valid) check("timeout_valid", 32'd0, 32'd1);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_diff", diff, 32'd0);
      rst = 1'b0;

      // 1: equal operands, busy for exactly four cycles
      issue(32'd5, 32'd5, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("busy_run", {31'd0, busy}, 32'd1);
         check("valid_run", {31'd0, valid}, 32'd0);
         @(negedge clk);
      end
      check("busy_after", {31'd0, busy}, 32'd0);
      check("valid_after", {31'd0, valid}, 32'd1);
      wait_done();

      // 2..3: negative result and signed overflow cases (restart from DONE)
      issue(32'd3, 32'd7, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
      wait_done();
      issue(32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
      wait_done();
      issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
      wait_done();

      // 4: start during RUN is ignored; outputs hold during RUN
      issue(32'd9, 32'd2, 1'b0, 32'd7, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("diff_hold", diff, 32'h8000_0000);
      start = 1'b1; a = 32'd0; b = 32'd0;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // Borrow crossing slices, and more signed corners
      issue(32'h0000_0100, 32'd1, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b1);
      wait_done();
      issue(32'd0, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
      wait_done();
      issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1);
      wait_done();

      // 5: reset mid-RUN clears everything, then a fresh operation works
      issue(32'd5, 32'd3, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_valid", {31'd0, valid}, 32'd0);
      check("mid_rst_neg", {31'd0, negative}, 32'd0);
      check("mid_rst_diff", diff, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      issue(32'd1, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
      wait_done();

`ifdef ALU_FLAG_UNSIGNED_EN
      // 6: unsigned versus signed compare of the same operands
      issue(32'd1, 32'hFFFF_FFFF, 1'b1, 32'd2, 1'b0, 1'b1, 1'b1);
      wait_done();
      issue(32'd1, 32'hFFFF_FFFF, 1'b0, 32'd2, 1'b0, 1'b0, 1'b1);
      wait_done();
`endif

      @(negedge clk);
      @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
